dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Sequences and shares the single-ported data memory between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sits between the pipeline stages and the data memory instance.
- Latches one request at a time, holds the memory controls stable for LATENCY cycles, returns read data and a one-cycle done pulse, and drives per-requester stall signals.
- MEM has priority over IF, with a starvation guard for IF.

Parameters:
- LATENCY, 1, memory access cycles in BUSY (legal range 1..15).
- STARVE_MAX, 3, consecutive IF losses after which IF wins the next arbitration (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- resetl  in  1  asynchronous active-low reset.
- if_req  in  1  IF read request; held high until if_done.
- if_addr  in  64  IF read address.
- if_done  out  1  one-cycle pulse: if_rdata is valid.
- if_rdata  out  64  registered IF read data.
- mem_rd  in  1  MEM load request; held until mem_done.
- mem_wr  in  1  MEM store request; held until mem_done.
- mem_addr  in  64  MEM address.
- mem_wdata  in  64  MEM store data.
- mem_done  out  1  one-cycle pulse: MEM access complete.
- mem_rdata  out  64  registered MEM load data.
- dm_addr  out  64  to data memory Address.
- dm_wdata  out  64  to data memory WriteData.
- dm_read  out  1  to data memory MemoryRead.
- dm_write  out  1  to data memory MemoryWrite.
- dm_rdata  in  64  from data memory ReadData.
- stall_if  out  1  equals if_req & ~if_done.
- stall_mem  out  1  equals (mem_rd | mem_wr) & ~mem_done.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset resetl is asynchronous, active-low.
- Reset: state=IDLE, owner=IF, cnt=0, starve_cnt=0. All outputs 0, including both rdata registers, dm_* and both done pulses. Applies immediately, including mid-access; the in-flight access is abandoned with no done pulse. dm_read and dm_write drop at the reset assertion.
- States: IDLE, BUSY, RESP.
- IDLE, arbitration on each rising edge:
  - MEM request = mem_rd | mem_wr.
  - If both requesters are active and starve_cnt==STARVE_MAX, IF wins; otherwise MEM wins.
  - A single active requester always wins.
  - On a grant: latch owner, dm_addr, dm_wdata (MEM only) and op. Set cnt=LATENCY-1. Go to BUSY.
  - If mem_rd and mem_wr are both high, the access is a write; mem_rdata is left unchanged.
- starve_cnt, updated on IDLE grant edges only:
  - Increments (saturating at STARVE_MAX) when MEM wins while if_req is high.
  - Clears to 0 when IF is granted.
  - Otherwise unchanged.
- BUSY:
  - dm_addr and dm_wdata come from the latched registers.
  - dm_read = latched read op; dm_write = latched write op. Both are held stable for all LATENCY cycles.
  - Each edge with cnt!=0 decrements cnt.
  - On the edge with cnt==0: for a read, capture dm_rdata into the owner's rdata register; then go to RESP.
- RESP:
  - The owner's done is high for exactly this cycle; dm_read and dm_write are 0.
  - Next edge: go to IDLE.
- Latency: request first seen high in IDLE cycle 0 gives done in cycle LATENCY+1. The next grant is no earlier than cycle LATENCY+2. Accesses are back-to-back with one IDLE cycle between them.
- Request withdrawn mid-access: the access still completes and done still pulses. The non-owner request is ignored until IDLE.
- Request inputs are sampled only in IDLE; address and data changes during BUSY or RESP have no effect.
- rdata registers hold their value until the next read by the same owner.

Test Plan:
- Reset then idle: resetl=0, then 1 with no requests -> all outputs 0, busy=0, dm_read=dm_write=0 for 10 cycles.
- IF read, LATENCY=1: if_req=1, if_addr=0x40, memory returns 0xDEAD -> dm_read=1 and dm_addr=0x40 in cycle 1; if_done=1 and if_rdata=0xDEAD in cycle 2; stall_if=1 in cycles 0-1.
- MEM store then load: mem_wr=1, addr=0x80, wdata=0x1234 until done; then mem_rd=1, addr=0x80 -> dm_write=1 for one cycle; mem_rdata=0x1234 with mem_done; if_done never pulses.
- Contention and starvation, STARVE_MAX=3: if_req held high, MEM issues 5 consecutive requests -> grant order MEM, MEM, MEM, IF, MEM, MEM; starve_cnt clears after the IF grant.
- Reset mid-access, LATENCY=4: assert resetl=0 during BUSY cnt=2 -> dm_read falls immediately, no done pulse, and a fresh request after release completes normally.
- Simultaneous mem_rd=mem_wr=1 -> write performed, mem_rdata unchanged from its prior value, mem_done pulses once.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester and data-memory signal bundle for dmem_port_arbiter
interface dmem_port_arbiter_if;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_done;
  logic [63:0] if_rdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_done;
  logic [63:0] mem_rdata;
  logic [63:0] dm_addr;
  logic [63:0] dm_wdata;
  logic        dm_read;
  logic        dm_write;
  logic [63:0] dm_rdata;
  logic        stall_if;
  logic        stall_mem;
  logic        busy;

  modport slave (
    input  if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, dm_rdata,
    output if_done, if_rdata, mem_done, mem_rdata, dm_addr, dm_wdata,
    output dm_read, dm_write, stall_if, stall_mem, busy
  );

  modport master (
    output if_req, if_addr, mem_rd, mem_wr, mem_addr, mem_wdata, dm_rdata,
    input  if_done, if_rdata, mem_done, mem_rdata, dm_addr, dm_wdata,
    input  dm_read, dm_write, stall_if, stall_mem, busy
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares one data memory port between IF fetch and MEM load/store
// MEM has priority; IF wins once it has lost STARVE_MAX consecutive arbitrations.
module dmem_port_arbiter #(
  parameter int LATENCY    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  resetl,
  dmem_port_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t     state;
  logic       owner_mem;
  logic [3:0] cnt;
  logic [3:0] starve_cnt;
  logic       mem_req;
  logic       if_win;

  assign mem_req       = bus.mem_rd | bus.mem_wr;
  assign if_win        = bus.if_req & (~mem_req | (starve_cnt == 4'(STARVE_MAX)));
  assign bus.busy      = (state != IDLE);
  assign bus.stall_if  = bus.if_req & ~bus.if_done;
  assign bus.stall_mem = mem_req & ~bus.mem_done;

  always_ff @(posedge clk or negedge resetl) begin
    if (!resetl) begin
      state         <= IDLE;
      owner_mem     <= 1'b0;
      cnt           <= '0;
      starve_cnt    <= '0;
      bus.if_done   <= 1'b0;
      bus.mem_done  <= 1'b0;
      bus.if_rdata  <= '0;
      bus.mem_rdata <= '0;
      bus.dm_addr   <= '0;
      bus.dm_wdata  <= '0;
      bus.dm_read   <= 1'b0;
      bus.dm_write  <= 1'b0;
    end else begin
      bus.if_done  <= 1'b0;
      bus.mem_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.if_req | mem_req) begin
            state     <= BUSY;
            cnt       <= 4'(LATENCY - 1);
            owner_mem <= ~if_win;
            if (if_win) begin
              bus.dm_addr  <= bus.if_addr;
              bus.dm_read  <= 1'b1;
              bus.dm_write <= 1'b0;
              starve_cnt   <= '0;
            end else begin
              // rd and wr together resolve to a write
              bus.dm_addr  <= bus.mem_addr;
              bus.dm_wdata <= bus.mem_wdata;
              bus.dm_write <= bus.mem_wr;
              bus.dm_read  <= ~bus.mem_wr;
              if (bus.if_req && (starve_cnt != 4'(STARVE_MAX)))
                starve_cnt <= starve_cnt + 4'd1;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (bus.dm_read) begin
              if (owner_mem) bus.mem_rdata <= bus.dm_rdata;
              else           bus.if_rdata  <= bus.dm_rdata;
            end
            bus.dm_read  <= 1'b0;
            bus.dm_write <= 1'b0;
            bus.if_done  <= ~owner_mem;
            bus.mem_done <= owner_mem;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed self-checking bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a;
  logic rst_b;
  int   n_tests = 0;
  int   n_fail  = 0;

  dmem_port_arbiter_if bus_a ();
  dmem_port_arbiter_if bus_b ();

  dmem_port_arbiter #(.LATENCY(1), .STARVE_MAX(3)) dut_a (.clk(clk), .resetl(rst_a), .bus(bus_a));
  dmem_port_arbiter #(.LATENCY(4), .STARVE_MAX(3)) dut_b (.clk(clk), .resetl(rst_b), .bus(bus_b));

  logic [63:0] mem_a [256];
  logic [63:0] mem_b [256];

  assign bus_a.dm_rdata = mem_a[bus_a.dm_addr[7:0]];
  assign bus_b.dm_rdata = mem_b[bus_b.dm_addr[7:0]];

  always @(posedge clk) begin
    if (!rst_a) mem_a[8'h40] <= 64'hDEAD;
    else if (bus_a.dm_write) mem_a[bus_a.dm_addr[7:0]] <= bus_a.dm_wdata;
  end

  always @(posedge clk) begin
    if (!rst_b) begin
      mem_b[8'h40] <= 64'h1111;
      mem_b[8'h48] <= 64'hBEEF;
    end else if (bus_b.dm_write) mem_b[bus_b.dm_addr[7:0]] <= bus_b.dm_wdata;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mem_access(input logic rd, input logic wr, input logic [63:0] addr,
                            input logic [63:0] wdata, output int wr_cycles,
                            output int if_pulses, output int done_cycle);
    wr_cycles  = 0;
    if_pulses  = 0;
    done_cycle = -1;
    bus_a.mem_rd    = rd;
    bus_a.mem_wr    = wr;
    bus_a.mem_addr  = addr;
    bus_a.mem_wdata = wdata;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_a.dm_write) wr_cycles++;
      if (bus_a.if_done) if_pulses++;
      if (bus_a.mem_done) begin
        done_cycle = k;
        break;
      end
    end
    bus_a.mem_rd = 1'b0;
    bus_a.mem_wr = 1'b0;
  endtask

  logic [7:0] exp_ord [7] = '{"M", "M", "M", "I", "M", "M", "I"};
  logic [7:0] ord [7];

  initial begin
    int wr_cycles, if_pulses, done_cycle, n_ord, mem_n, if_n, extra;

    bus_a.if_req = 0; bus_a.if_addr = 0; bus_a.mem_rd = 0; bus_a.mem_wr = 0;
    bus_a.mem_addr = 0; bus_a.mem_wdata = 0;
    bus_b.if_req = 0; bus_b.if_addr = 0; bus_b.mem_rd = 0; bus_b.mem_wr = 0;
    bus_b.mem_addr = 0; bus_b.mem_wdata = 0;
    rst_a = 0;
    rst_b = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus_a.busy), 64'd0);
    check("rst_if_rdata", bus_a.if_rdata, 64'd0);
    check("rst_mem_rdata", bus_a.mem_rdata, 64'd0);
    check("rst_dm_addr", bus_a.dm_addr, 64'd0);
    rst_a = 1;
    rst_b = 1;

    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_outs", 64'({bus_a.busy, bus_a.dm_read, bus_a.dm_write, bus_a.if_done,
                             bus_a.mem_done, bus_a.stall_if, bus_a.stall_mem}), 64'd0);
    end

    // IF read, LATENCY=1
    bus_a.if_req  = 1;
    bus_a.if_addr = 64'h40;
    #1 check("if_stall_c0", 64'(bus_a.stall_if), 64'd1);
    @(negedge clk);
    check("if_dm_read_c1", 64'(bus_a.dm_read), 64'd1);
    check("if_dm_addr_c1", bus_a.dm_addr, 64'h40);
    check("if_stall_c1", 64'(bus_a.stall_if), 64'd1);
    check("if_done_c1", 64'(bus_a.if_done), 64'd0);
    @(negedge clk);
    check("if_done_c2", 64'(bus_a.if_done), 64'd1);
    check("if_rdata_c2", bus_a.if_rdata, 64'hDEAD);
    check("if_stall_c2", 64'(bus_a.stall_if), 64'd0);
    check("if_dm_read_c2", 64'(bus_a.dm_read), 64'd0);
    bus_a.if_req = 0;
    @(negedge clk);
    check("if_busy_c3", 64'(bus_a.busy), 64'd0);

    // MEM store then load
    mem_access(1'b0, 1'b1, 64'h80, 64'h1234, wr_cycles, if_pulses, done_cycle);
    check("st_done_cycle", 64'(done_cycle), 64'd2);
    check("st_wr_cycles", 64'(wr_cycles), 64'd1);
    check("st_no_if_done", 64'(if_pulses), 64'd0);
    @(negedge clk);
    mem_access(1'b1, 1'b0, 64'h80, 64'h0, wr_cycles, if_pulses, done_cycle);
    check("ld_done_cycle", 64'(done_cycle), 64'd2);
    check("ld_rdata", bus_a.mem_rdata, 64'h1234);
    check("ld_wr_cycles", 64'(wr_cycles), 64'd0);
    check("ld_no_if_done", 64'(if_pulses), 64'd0);
    @(negedge clk);

    // rd and wr together act as a write
    mem_access(1'b1, 1'b1, 64'h88, 64'h5555, wr_cycles, if_pulses, done_cycle);
    check("rw_done_cycle", 64'(done_cycle), 64'd2);
    check("rw_wr_cycles", 64'(wr_cycles), 64'd1);
    check("rw_rdata_kept", bus_a.mem_rdata, 64'h1234);
    extra = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus_a.mem_done) extra++;
    end
    check("rw_single_done", 64'(extra), 64'd0);
    check("rw_mem_written", mem_a[8'h88], 64'h5555);

    // contention with starvation guard
    bus_a.if_req   = 1;
    bus_a.if_addr  = 64'h40;
    bus_a.mem_rd   = 1;
    bus_a.mem_addr = 64'h80;
    n_ord = 0; mem_n = 0; if_n = 0;
    for (int k = 0; k < 200 && n_ord < 7; k++) begin
      @(negedge clk);
      if (bus_a.mem_done) begin
        ord[n_ord] = "M"; n_ord++; mem_n++;
        if (mem_n == 5) bus_a.mem_rd = 0;
      end
      if (bus_a.if_done) begin
        ord[n_ord] = "I"; n_ord++; if_n++;
        if (if_n == 2) bus_a.if_req = 0;
      end
    end
    bus_a.if_req = 0;
    bus_a.mem_rd = 0;
    check("arb_grant_count", 64'(n_ord), 64'd7);
    for (int i = 0; i < 7; i++)
      if (i < n_ord) check($sformatf("arb_order_%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
    check("arb_if_rdata", bus_a.if_rdata, 64'hDEAD);
    check("arb_mem_rdata", bus_a.mem_rdata, 64'h1234);
    @(negedge clk);

    // reset in the middle of a LATENCY=4 access
    bus_b.if_req  = 1;
    bus_b.if_addr = 64'h40;
    repeat (2) @(negedge clk);
    check("mid_dm_read_before", 64'(bus_b.dm_read), 64'd1);
    rst_b = 0;
    bus_b.if_req = 0;
    #1;
    check("mid_dm_read_drop", 64'(bus_b.dm_read), 64'd0);
    check("mid_busy_drop", 64'(bus_b.busy), 64'd0);
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus_b.if_done | bus_b.mem_done) extra++;
    end
    check("mid_no_done", 64'(extra), 64'd0);
    check("mid_if_rdata", bus_b.if_rdata, 64'd0);
    rst_b = 1;
    bus_b.if_req  = 1;
    bus_b.if_addr = 64'h48;
    done_cycle = -1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus_b.if_done) begin
        done_cycle = k;
        break;
      end
    end
    bus_b.if_req = 0;
    check("mid_fresh_done_cycle", 64'(done_cycle), 64'd5);
    check("mid_fresh_rdata", bus_b.if_rdata, 64'hBEEF);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
